// File: rtl/channel_cmd_driver_pkg.sv
// Shared definitions for the channel command driver and the memory-side
// channel model's command decoder.
//   cmd_t   : CA bus command encoding (NOP/ACT/RD/WR/PRE)
//   state_t : driver FSM states
//   cnt_max : helper used to size the wait counter
package MemoryController_Definitions;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3,
    PRE = 3'd4
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACT      = 3'd1,
    S_WAIT_RCD = 3'd2,
    S_CAS      = 3'd3,
    S_DATA     = 3'd4,
    S_PRE      = 3'd5,
    S_WAIT_RP  = 3'd6
  } state_t;

  function automatic int unsigned cnt_max(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/channel_cmd_driver.sv
// Closed-page DDR4 CA/DQ driver, one transaction outstanding.
// Each accepted request issues ACT, then RD or WR tRCD cycles later, moves
// the data burst, issues a single-bank PRE right after the last beat and
// becomes ready again tRP cycles after PRE.
// Ports:
//   clk, rst          clock, async active-high reset
//   req_*             request handshake, direction, address and write burst
//   rd_valid/rd_data  completed read burst (beat 0 in LSBs), held until next read
//   ca_cs_n/ca_cmd/ca_bg/ca_bk/ca_addr   registered command/address bus
//   dq_out/dq_oe      registered write beat and its valid
//   dq_in             read beat from memory
module channel_cmd_driver
  import MemoryController_Definitions::*;
#(
  parameter int unsigned NUMRANK       = 4,
  parameter int unsigned RKWIDTH       = 2,
  parameter int unsigned BGWIDTH       = 2,
  parameter int unsigned BKWIDTH       = 2,
  parameter int unsigned RWIDTH        = 15,
  parameter int unsigned CWIDTH        = 10,
  parameter int unsigned MEM_DATAWIDTH = 64,
  parameter int unsigned BURST_LENGTH  = 8,
  parameter int unsigned tRCD          = 16,
  parameter int unsigned tCL           = 16,
  parameter int unsigned tCWL          = 12,
  parameter int unsigned tRP           = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_write,
  input  logic [RKWIDTH-1:0]                    req_rank,
  input  logic [BGWIDTH-1:0]                    req_bg,
  input  logic [BKWIDTH-1:0]                    req_bk,
  input  logic [RWIDTH-1:0]                     req_row,
  input  logic [CWIDTH-1:0]                     req_col,
  input  logic [MEM_DATAWIDTH*BURST_LENGTH-1:0] req_wdata,
  output logic                                  rd_valid,
  output logic [MEM_DATAWIDTH*BURST_LENGTH-1:0] rd_data,
  output logic [NUMRANK-1:0]                    ca_cs_n,
  output cmd_t                                  ca_cmd,
  output logic [BGWIDTH-1:0]                    ca_bg,
  output logic [BKWIDTH-1:0]                    ca_bk,
  output logic [RWIDTH-1:0]                     ca_addr,
  output logic [MEM_DATAWIDTH-1:0]              dq_out,
  output logic                                  dq_oe,
  input  logic [MEM_DATAWIDTH-1:0]              dq_in
);

  localparam int unsigned BW     = MEM_DATAWIDTH * BURST_LENGTH;
  localparam int unsigned MW     = MEM_DATAWIDTH;
  localparam int unsigned CNTMAX = cnt_max(tRCD, tRP, tCL + BURST_LENGTH, tCWL + BURST_LENGTH);
  localparam int unsigned CNTW   = $clog2(CNTMAX + 1);

  // cnt counts cycles since the most recent command (0 in the command cycle)
  localparam logic [CNTW-1:0] RCD_END = CNTW'(tRCD - 1);
  localparam logic [CNTW-1:0] RP_END  = CNTW'(tRP - 1);
  localparam logic [CNTW-1:0] RD_END  = CNTW'(tCL + BURST_LENGTH - 1);
  localparam logic [CNTW-1:0] WR_END  = CNTW'(tCWL + BURST_LENGTH - 1);
  localparam logic [CNTW-1:0] RL      = CNTW'(tCL);
  localparam logic [CNTW-1:0] WL      = CNTW'(tCWL);

  state_t              state, state_nx;
  logic [CNTW-1:0]     cnt, cnt_nx;

  logic                wr_q;
  logic [RKWIDTH-1:0]  rank_q;
  logic [BGWIDTH-1:0]  bg_q;
  logic [BKWIDTH-1:0]  bk_q;
  logic [CWIDTH-1:0]   col_q;
  logic [BW-1:0]       wbuf;
  // Holds the first BURST_LENGTH-1 beats; the last beat goes straight to rd_data.
  logic [BW-MW-1:0]    rbuf;

  logic                accept;
  logic                rd_sample;
  logic                rd_done;
  logic                dq_oe_nx;
  cmd_t                cmd_nx;
  logic [NUMRANK-1:0]  cs_nx;
  logic [BGWIDTH-1:0]  bg_nx;
  logic [BKWIDTH-1:0]  bk_nx;
  logic [RWIDTH-1:0]   addr_nx;

  assign req_ready = (state == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Outputs are registered from next-state values so each command appears
  // in the same cycle the FSM occupies the matching state.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + CNTW'(1);
    cmd_nx    = NOP;
    cs_nx     = '1;
    bg_nx     = '0;
    bk_nx     = '0;
    addr_nx   = '0;
    dq_oe_nx  = 1'b0;
    rd_sample = 1'b0;
    rd_done   = 1'b0;

    case (state)
      S_IDLE:     if (accept) state_nx = S_ACT;
      S_ACT:      state_nx = S_WAIT_RCD;
      S_WAIT_RCD: if (cnt == RCD_END) state_nx = S_CAS;
      S_CAS:      state_nx = S_DATA;
      S_DATA:     if (cnt == (wr_q ? WR_END : RD_END)) state_nx = S_PRE;
      S_PRE:      state_nx = S_WAIT_RP;
      S_WAIT_RP:  if (cnt == RP_END) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase

    case (state_nx)
      S_IDLE, S_ACT, S_CAS, S_PRE: cnt_nx = '0;
      default: ;
    endcase

    case (state_nx)
      S_ACT: begin
        // ACT is only entered from the accepting edge, so use the live request
        cmd_nx            = ACT;
        cs_nx[req_rank]   = 1'b0;
        bg_nx             = req_bg;
        bk_nx             = req_bk;
        addr_nx           = req_row;
      end
      S_CAS: begin
        cmd_nx            = wr_q ? WR : RD;
        cs_nx[rank_q]     = 1'b0;
        bg_nx             = bg_q;
        bk_nx             = bk_q;
        addr_nx           = RWIDTH'(col_q);
      end
      S_PRE: begin
        // addr stays zero: A10=0 selects single-bank precharge
        cmd_nx            = PRE;
        cs_nx[rank_q]     = 1'b0;
        bg_nx             = bg_q;
        bk_nx             = bk_q;
      end
      default: ;
    endcase

    dq_oe_nx  = (state_nx == S_DATA) && wr_q && (cnt_nx >= WL);
    rd_sample = (state == S_DATA) && !wr_q && (cnt >= RL);
    rd_done   = rd_sample && (state_nx == S_PRE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      wr_q     <= 1'b0;
      rank_q   <= '0;
      bg_q     <= '0;
      bk_q     <= '0;
      col_q    <= '0;
      wbuf     <= '0;
      rbuf     <= '0;
      ca_cmd   <= NOP;
      ca_cs_n  <= '1;
      ca_bg    <= '0;
      ca_bk    <= '0;
      ca_addr  <= '0;
      dq_oe    <= 1'b0;
      dq_out   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      ca_cmd  <= cmd_nx;
      ca_cs_n <= cs_nx;
      ca_bg   <= bg_nx;
      ca_bk   <= bk_nx;
      ca_addr <= addr_nx;

      if (accept) begin
        wr_q   <= req_write;
        rank_q <= req_rank;
        bg_q   <= req_bg;
        bk_q   <= req_bk;
        col_q  <= req_col;
        wbuf   <= req_wdata;
      end

      dq_oe <= dq_oe_nx;
      if (dq_oe_nx) begin
        dq_out <= wbuf[MW-1:0];
        wbuf   <= wbuf >> MW;
      end else begin
        dq_out <= '0;
      end

      if (rd_sample) rbuf <= {dq_in, rbuf[BW-MW-1:MW]};

      rd_valid <= rd_done;
      if (rd_done) rd_data <= {dq_in, rbuf};
    end
  end

endmodule

// File: doc/channel_cmd_driver.md
CHANNEL_CMD_DRIVER -- requirements
Module: channel_cmd_driver

Interface
REQ-001 SHALL have parameter NUMRANK, default 4: ranks on the channel.
REQ-002 SHALL have parameter RKWIDTH, default 2: rank index width, equal to log2(NUMRANK).
REQ-003 SHALL have parameters BGWIDTH=2, BKWIDTH=2, RWIDTH=15, CWIDTH=10: bank-group, bank, row and column address widths.
REQ-004 SHALL have parameters MEM_DATAWIDTH=64 and BURST_LENGTH=8: DQ beat width and beats per burst.
REQ-005 SHALL have timing parameters tRCD=16, tCL=16, tCWL=12, tRP=16, all in clk cycles, each at least 2.
REQ-006 Ports, in this order:
  clk  in  1  sole clock, rising edge; one clock, reset is asynchronous and active-high
  rst  in  1  asynchronous active-high reset
  req_valid  in  1  request present
  req_ready  out  1  block can accept a request
  req_write  in  1  1=write, 0=read
  req_rank/req_bg/req_bk/req_row/req_col  in  RKWIDTH/BGWIDTH/BKWIDTH/RWIDTH/CWIDTH  target address
  req_wdata  in  MEM_DATAWIDTH*BURST_LENGTH  write burst, beat 0 in the LSBs
  rd_valid  out  1  one-cycle pulse when rd_data holds a completed read burst
  rd_data  out  MEM_DATAWIDTH*BURST_LENGTH  read burst, beat 0 in the LSBs
  ca_cs_n  out  NUMRANK  per-rank chip select, active-low
  ca_cmd  out  cmd_t  NOP/ACT/RD/WR/PRE
  ca_bg/ca_bk/ca_addr  out  BGWIDTH/BKWIDTH/RWIDTH  command address
  dq_out  out  MEM_DATAWIDTH  write beat
  dq_oe  out  1  write beat valid on dq_out
  dq_in  in  MEM_DATAWIDTH  read beat from memory

Function
REQ-007 Closed-page controller-side driver for the DDR4 CA/DQ bus, one transaction outstanding: ACT, then RD or WR, then PRE.
REQ-008 FSM states and transitions: IDLE -> ACT -> WAIT_RCD -> CAS -> DATA -> PRE -> WAIT_RP -> IDLE.
REQ-009 req_ready SHALL be 1 only in IDLE. A request is accepted on a clk edge where req_valid && req_ready; all req_* fields are captured at that edge.
REQ-010 All CA/DQ outputs SHALL be registered. The cycle after acceptance SHALL drive ACT, with ca_addr=row and bank/bank group from the request.
REQ-011 RD or WR SHALL be driven exactly tRCD cycles after the ACT cycle, with ca_addr = column zero-extended to RWIDTH.
REQ-012 PRE SHALL drive ca_addr[10]=0 (single-bank precharge) and the same bank group and bank as the ACT.
REQ-013 During ACT/RD/WR/PRE, ca_cs_n[req_rank] SHALL be 0 and all other bits 1. In every other cycle, ca_cmd=NOP and ca_cs_n is all ones.
REQ-014 Write data: dq_oe SHALL be 1 for cycles WR+tCWL .. WR+tCWL+BURST_LENGTH-1, and dq_out SHALL carry beat i in cycle WR+tCWL+i. dq_oe=0 and dq_out=0 otherwise.
REQ-015 Read data: dq_in SHALL be sampled as beat i at the edge ending cycle RD+tCL+i. rd_valid SHALL pulse in cycle RD+tCL+BURST_LENGTH with the full burst on rd_data. rd_data SHALL hold its value until the next read completes.
REQ-016 PRE SHALL be driven in the cycle after the last data beat: RD+tCL+BURST_LENGTH or WR+tCWL+BURST_LENGTH.
REQ-017 req_ready SHALL reassert exactly tRP cycles after the PRE cycle.
REQ-018 The wait counter SHALL be wide enough for max(tRCD,tRP,tCL+BURST_LENGTH,tCWL+BURST_LENGTH) without wrap. Beat index wraps only at the end of a burst.
REQ-019 Back-to-back requests: a request valid in the cycle req_ready reasserts SHALL be accepted at that edge, giving no gap beyond REQ-017.

Reset
REQ-020 While rst=1: FSM=IDLE, req_ready=0, rd_valid=0, rd_data=0, ca_cmd=NOP, ca_cs_n all ones, ca_bg/ca_bk/ca_addr=0, dq_oe=0, dq_out=0, counters=0. req_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-021 Reset asserted mid-transaction SHALL abort it immediately: no PRE is issued, no rd_valid pulse occurs, and the burst is discarded.

Structure
REQ-022 cmd_t (NOP, ACT, RD, WR, PRE) SHALL be defined in package MemoryController_Definitions, shared with the memory-side channel model's decoder.
REQ-023 The block SHALL be a single module with no sub-modules. The burst shift registers are internal.

Verification
REQ-024 Read with defaults: accept at cycle 0 -> ACT at 1, RD at 17, beats sampled 33..40, rd_valid and PRE at 41, req_ready at 57.
REQ-025 Write with wdata beats 0x11..0x88, rank 2 -> ACT at 1, WR at 17, dq_oe cycles 29..36 carrying beats in order, PRE at 37, ca_cs_n=4'b1011 on every command.
REQ-026 Read with row=0x7FFF, col=0x3FF, bg=3, bk=3 -> ca_addr=0x7FFF on ACT, 0x03FF on RD, bit10=0 on PRE; bg/bk=3 on all three commands.
REQ-027 req_valid held high for three reads -> accepted at cycles 0, 57 and 114; no command overlap.
REQ-028 rst pulsed at cycle 35 of a read -> outputs at reset values within the same cycle, no rd_valid, no PRE; a new request after release follows REQ-024 timing.
